// File: rtl/octree_axi_pkg.sv
// Shared definitions for the octree/BFS DDR transaction path: scheduler state
// encoding, point-to-byte shift, and default DDR base addresses.
package octree_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_WAIT  = 3'd5,
        ST_DONE     = 3'd6
    } sched_state_t;

    localparam int unsigned POINT_SHIFT = 3;

    localparam logic [31:0] DEF_DDR_RD_BASE = 32'h0F00_0000;
    localparam logic [31:0] DEF_DDR_WR_BASE = 32'h0F80_0000;

endpackage

// File: rtl/ddr_txn_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter (read vs write). The last-served flag moves
// only when a grant is accepted; i_clear makes read win the next tie.
module rr_arbiter2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_accept,
    input  logic i_req_rd,
    input  logic i_req_wr,
    output logic o_gnt_rd,
    output logic o_gnt_wr
);

    logic last_rd;

    always_comb begin
        o_gnt_rd = i_req_rd && (!i_req_wr || !last_rd);
        o_gnt_wr = i_req_wr && !o_gnt_rd;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
            last_rd <= 1'b0;
        end else if (i_accept && (o_gnt_rd || o_gnt_wr)) begin
            last_rd <= o_gnt_rd;
        end
    end

endmodule

// File: rtl/ddr_txn_scheduler.sv
// Shares one AXI master between octree point reads and BFS occupancy writes.
// Optional per-direction transaction counters under `TXN_STATS_EN.
//   state    | meaning
//   IDLE     | waiting for i_start
//   ARB      | sample requests, pick read or write
//   RD_ISSUE | read address valid, init pulse
//   RD_WAIT  | wait for read completion
//   WR_ISSUE | write address valid, latch wr_last, init pulse
//   WR_WAIT  | wait for write completion
//   DONE     | frame end pulse issued next cycle
module ddr_txn_scheduler
    import octree_axi_pkg::*;
#(
    parameter logic [31:0] DDR_RD_BASE_ADDRESS = DEF_DDR_RD_BASE,
    parameter logic [31:0] DDR_WR_BASE_ADDRESS = DEF_DDR_WR_BASE,
    parameter int unsigned BURST_POINTS        = 16,
    parameter int unsigned WR_BURST_BYTES      = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_point_cloud_size,
    input  logic        i_rd_req,
    input  logic        i_wr_req,
    input  logic        i_wr_last,
    input  logic        i_read_txn_done,
    input  logic        i_write_txn_done,
    output logic        o_init_read_txn,
    output logic        o_init_write_txn,
    output logic [31:0] o_read_address,
    output logic [31:0] o_write_address,
    output logic [8:0]  o_rd_points,
    output logic        o_rd_grant,
    output logic        o_wr_grant,
    output logic        o_rd_exhausted,
    output logic        o_busy,
`ifdef TXN_STATS_EN
    output logic [15:0] o_rd_txn_count,
    output logic [15:0] o_wr_txn_count,
`endif
    output logic        o_frame_done
);

    localparam int unsigned WR_SHIFT   = $clog2(WR_BURST_BYTES);
    localparam logic [31:0] BURST_P32  = 32'(BURST_POINTS);

    sched_state_t state, state_nxt;
    logic [31:0]  size_q, fetched_q, written_q, remaining;
    logic         wr_last_q, exhausted, rd_elig, wr_elig, gnt_rd, gnt_wr;
    logic         rd_done_ev, wr_done_ev, start_ev;

    assign exhausted  = (fetched_q >= size_q);
    assign remaining  = size_q - fetched_q;
    assign start_ev   = (state == ST_IDLE) && i_start;
    assign rd_done_ev = (state == ST_RD_WAIT) && i_read_txn_done;
    assign wr_done_ev = (state == ST_WR_WAIT) && i_write_txn_done;

    // Requests are ignored in the grant cycle: the core may still hold the
    // request it just had served until it sees the grant.
    assign rd_elig = i_rd_req && !exhausted && !o_rd_grant && !o_wr_grant;
    assign wr_elig = i_wr_req && !o_rd_grant && !o_wr_grant;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (start_ev),
        .i_accept (state == ST_ARB),
        .i_req_rd (rd_elig),
        .i_req_wr (wr_elig),
        .o_gnt_rd (gnt_rd),
        .o_gnt_wr (gnt_wr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (i_start) state_nxt = ST_ARB;
            ST_ARB: begin
                if (gnt_rd)      state_nxt = ST_RD_ISSUE;
                else if (gnt_wr) state_nxt = ST_WR_ISSUE;
            end
            ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  if (i_read_txn_done) state_nxt = ST_ARB;
            ST_WR_ISSUE: state_nxt = ST_WR_WAIT;
            ST_WR_WAIT:  if (i_write_txn_done) state_nxt = wr_last_q ? ST_DONE : ST_ARB;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign o_init_read_txn  = (state == ST_RD_ISSUE);
    assign o_init_write_txn = (state == ST_WR_ISSUE);
    assign o_busy           = (state != ST_IDLE);
    assign o_rd_exhausted   = o_busy && exhausted;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state           <= ST_IDLE;
            size_q          <= '0;
            fetched_q       <= '0;
            written_q       <= '0;
            wr_last_q       <= 1'b0;
            o_read_address  <= DDR_RD_BASE_ADDRESS;
            o_write_address <= DDR_WR_BASE_ADDRESS;
            o_rd_points     <= '0;
            o_rd_grant      <= 1'b0;
            o_wr_grant      <= 1'b0;
            o_frame_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_rd_grant   <= rd_done_ev;
            o_wr_grant   <= wr_done_ev;
            o_frame_done <= (state == ST_DONE);
            case (state)
                ST_IDLE: if (i_start) begin
                    size_q    <= i_point_cloud_size;
                    fetched_q <= '0;
                    written_q <= '0;
                    wr_last_q <= 1'b0;
                end
                ST_ARB: begin
                    if (gnt_rd) begin
                        o_read_address <= DDR_RD_BASE_ADDRESS + (fetched_q << POINT_SHIFT);
                        o_rd_points    <= (remaining < BURST_P32) ? remaining[8:0] : BURST_P32[8:0];
                    end else if (gnt_wr) begin
                        o_write_address <= DDR_WR_BASE_ADDRESS + (written_q << WR_SHIFT);
                    end
                end
                ST_RD_WAIT:  if (i_read_txn_done) fetched_q <= fetched_q + 32'(o_rd_points);
                ST_WR_ISSUE: wr_last_q <= i_wr_last;
                ST_WR_WAIT:  if (i_write_txn_done) written_q <= written_q + 32'd1;
                default: ;
            endcase
        end
    end

`ifdef TXN_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst || start_ev) begin
            o_rd_txn_count <= '0;
            o_wr_txn_count <= '0;
        end else begin
            if (rd_done_ev && o_rd_txn_count != 16'hFFFF) o_rd_txn_count <= o_rd_txn_count + 16'd1;
            if (wr_done_ev && o_wr_txn_count != 16'hFFFF) o_wr_txn_count <= o_wr_txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_txn_scheduler.sv
// Directed bench for ddr_txn_scheduler: expected transactions are queued when a
// request is raised and compared when the matching init pulse appears.
module tb_ddr_txn_scheduler;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [8:0]  pts;
    } txn_t;

    logic        clk, rst, start, rd_req, wr_req, wr_last, rd_done, wr_done;
    logic [31:0] size;
    logic        init_rd, init_wr, rd_grant, wr_grant, rd_exh, busy, frame_done;
    logic [31:0] rd_addr, wr_addr;
    logic [8:0]  rd_pts;
`ifdef TXN_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    txn_t exp_q[$];

    ddr_txn_scheduler dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_point_cloud_size (size),
        .i_rd_req           (rd_req),
        .i_wr_req           (wr_req),
        .i_wr_last          (wr_last),
        .i_read_txn_done    (rd_done),
        .i_write_txn_done   (wr_done),
        .o_init_read_txn    (init_rd),
        .o_init_write_txn   (init_wr),
        .o_read_address     (rd_addr),
        .o_write_address    (wr_addr),
        .o_rd_points        (rd_pts),
        .o_rd_grant         (rd_grant),
        .o_wr_grant         (wr_grant),
        .o_rd_exhausted     (rd_exh),
        .o_busy             (busy),
`ifdef TXN_STATS_EN
        .o_rd_txn_count     (rd_cnt),
        .o_wr_txn_count     (wr_cnt),
`endif
        .o_frame_done       (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input logic [31:0] addr, input logic [8:0] pts);
        txn_t t;
        t.wr = wr; t.addr = addr; t.pts = pts;
        exp_q.push_back(t);
    endtask

    // Waits (bounded) for an init pulse and checks it against the queue head.
    task automatic wait_txn(output int cyc);
        bit   found;
        txn_t e;
        found = 0;
        cyc   = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (init_rd || init_wr) found = 1;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL txn_timeout observed=none expected=init_pulse");
        end
        if (found) begin
            chk("init_exclusive", {31'd0, init_rd & init_wr}, 32'd0);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=unexpected_txn expected=none");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("txn_kind", {31'd0, init_wr}, {31'd0, e.wr});
                if (e.wr) begin
                    chk("wr_addr", wr_addr, e.addr);
                end else begin
                    chk("rd_addr", rd_addr, e.addr);
                    chk("rd_points", {23'd0, rd_pts}, {23'd0, e.pts});
                end
            end
        end
    endtask

    task automatic complete(input bit wr, input bit drop);
        @(negedge clk);
        chk("init_width", {31'd0, wr ? init_wr : init_rd}, 32'd0);
        if (wr) wr_done = 1'b1; else rd_done = 1'b1;
        @(negedge clk);
        chk(wr ? "wr_grant" : "rd_grant", {31'd0, wr ? wr_grant : rd_grant}, 32'd1);
        chk("other_grant", {31'd0, wr ? rd_grant : wr_grant}, 32'd0);
        rd_done = 1'b0;
        wr_done = 1'b0;
        if (drop) begin
            if (wr) wr_req = 1'b0; else rd_req = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b0; start = 1'b0; size = '0; rd_req = 1'b0; wr_req = 1'b0;
        wr_last = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_exh", {31'd0, rd_exh}, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'h0F00_0000);
        chk("rst_wr_addr", wr_addr, 32'h0F80_0000);
        chk("rst_points", {23'd0, rd_pts}, 32'd0);
        chk("rst_pulses", {27'd0, init_rd, init_wr, rd_grant, wr_grant, frame_done}, 32'd0);
        rst = 1'b1;

        // Frame A: 40 points, interleaved writes
        @(negedge clk);
        size = 32'd40; start = 1'b1; rd_req = 1'b1;
        push(0, 32'h0F00_0000, 9'd16);
        @(negedge clk);
        start = 1'b0;
        chk("arb_busy", {31'd0, busy}, 32'd1);
        chk("arb_exh", {31'd0, rd_exh}, 32'd0);
        wait_txn(cyc);
        chk("start_latency", cyc, 32'd1);
        complete(0, 1);

        rd_req = 1'b1;
        push(0, 32'h0F00_0080, 9'd16);
        wait_txn(cyc);
        complete(0, 0);

        wr_req = 1'b1;
        push(1, 32'h0F80_0000, 9'd0);
        push(0, 32'h0F00_0100, 9'd8);
        wait_txn(cyc);
        chk("done_to_init", cyc, 32'd2);
        complete(1, 1);
        wait_txn(cyc);
        chk("rr_read_after_write", cyc, 32'd2);
        complete(0, 0);
        chk("exhausted", {31'd0, rd_exh}, 32'd1);

        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (init_rd) seen++;
        end
        chk("no_read_when_exhausted", seen, 32'd0);

        wr_req = 1'b1;
        push(1, 32'h0F80_0040, 9'd0);
        wait_txn(cyc);
        complete(1, 1);
        wr_req = 1'b1; wr_last = 1'b1;
        push(1, 32'h0F80_0080, 9'd0);
        wait_txn(cyc);
        complete(1, 1);
        wr_last = 1'b0; rd_req = 1'b0;
        chk("frame_done_early", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        chk("frame_done", {31'd0, frame_done}, 32'd1);
        @(negedge clk);
        chk("frame_done_width", {31'd0, frame_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
`ifdef TXN_STATS_EN
        chk("rd_txn_count", {16'd0, rd_cnt}, 32'd3);
        chk("wr_txn_count", {16'd0, wr_cnt}, 32'd3);
`endif

        // Frame B: empty point cloud
        size = 32'd0; start = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_exh", {31'd0, rd_exh}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd1);
`ifdef TXN_STATS_EN
        chk("rd_cnt_clear", {16'd0, rd_cnt}, 32'd0);
        chk("wr_cnt_clear", {16'd0, wr_cnt}, 32'd0);
`endif
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (init_rd) seen++;
        end
        chk("zero_no_read", seen, 32'd0);
        wr_req = 1'b1; wr_last = 1'b1;
        push(1, 32'h0F80_0000, 9'd0);
        wait_txn(cyc);
        complete(1, 1);
        wr_last = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        chk("zero_frame_done", {31'd0, frame_done}, 32'd1);
        @(negedge clk);
        chk("zero_idle", {31'd0, busy}, 32'd0);

        // Frame C: reset while a read is in flight
        size = 32'd40; start = 1'b1; rd_req = 1'b1;
        push(0, 32'h0F00_0000, 9'd16);
        @(negedge clk);
        start = 1'b0;
        wait_txn(cyc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rd_addr", rd_addr, 32'h0F00_0000);
        chk("mid_rst_points", {23'd0, rd_pts}, 32'd0);
        chk("mid_rst_pulses", {26'd0, rd_exh, init_rd, init_wr, rd_grant, wr_grant, frame_done}, 32'd0);
        rst = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("stray_done_grant", {31'd0, rd_grant}, 32'd0);
        @(negedge clk);
        chk("stray_done_busy", {31'd0, busy}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
